// File: rtl/iob_eth_mii_tx.sv
// iob_eth_mii_tx: MII transmit engine adding preamble/SFD, padding, CRC-32 FCS and inter-frame gap
module iob_eth_mii_tx #(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MIN_FRAME_LEN = 60,
  parameter int PAD_EN        = 1,
  parameter int IFG_LEN       = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        send_i,
  input  logic [10:0] frame_len_i,
  output logic        ready_o,
  output logic        tx_done_o,
  output logic        rd_o,
  output logic [10:0] addr_o,
  input  logic [7:0]  data_i,
  output logic        tx_en_o,
  output logic [3:0]  tx_data_o
);
  localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, SFD = 3'd2, DATA = 3'd3, PAD = 3'd4, FCS = 3'd5, IFG = 3'd6;
  localparam logic [7:0] PRE_LAST = 8'(2 * PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(2 * IFG_LEN - 2);
  localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME_LEN);
  logic [2:0] st;
  logic [7:0] cnt;
  logic [10:0] len, bc;
  logic ph;
  logic [3:0] hi;
  logic [31:0] crc;
  logic [11:0] tgt, nb, nb1;
  logic adv;
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'd0, n};
    for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  // total body bytes, index of the next body byte, and when the body advances to a new byte
  assign tgt = (PAD_EN != 0 && {1'b0, len} < MIN_LEN) ? MIN_LEN : {1'b0, len};
  assign nb  = (st == SFD) ? 12'd0 : {1'b0, bc} + 12'd1;
  assign nb1 = nb + 12'd1;
  assign adv = (st == SFD && cnt == 8'd1) || ((st == DATA || st == PAD) && ph);
  // frame sequencer; every output is registered and the next byte is read one byte ahead
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= IDLE;
      cnt <= 8'd0;
      len <= 11'd0;
      bc <= 11'd0;
      ph <= 1'b0;
      hi <= 4'd0;
      crc <= 32'hFFFFFFFF;
      ready_o <= 1'b1;
      tx_done_o <= 1'b0;
      rd_o <= 1'b0;
      addr_o <= 11'd0;
      tx_en_o <= 1'b0;
      tx_data_o <= 4'd0;
    end else begin
      rd_o <= 1'b0;
      tx_done_o <= 1'b0;
      if (adv) begin
        if (nb < {1'b0, len}) begin
          st <= DATA;
          bc <= nb[10:0];
          ph <= 1'b0;
          tx_data_o <= data_i[3:0];
          hi <= data_i[7:4];
          crc <= crc_nib(crc, data_i[3:0]);
          rd_o <= nb1 < {1'b0, len};
          if (nb1 < {1'b0, len}) addr_o <= nb1[10:0];
        end else if (nb < tgt) begin
          st <= PAD;
          bc <= nb[10:0];
          ph <= 1'b0;
          tx_data_o <= 4'd0;
          crc <= crc_nib(crc, 4'd0);
        end else begin
          st <= FCS;
          cnt <= 8'd0;
          tx_data_o <= ~crc[3:0];
          crc <= crc >> 4;
        end
      end else begin
        case (st)
          IDLE: if (send_i) begin
            len <= frame_len_i;
            st <= PREAMBLE;
            cnt <= 8'd0;
            tx_en_o <= 1'b1;
            tx_data_o <= 4'h5;
            crc <= 32'hFFFFFFFF;
            ready_o <= 1'b0;
          end
          PREAMBLE: begin
            tx_data_o <= 4'h5;
            cnt <= cnt + 8'd1;
            if (cnt == PRE_LAST) begin
              st <= SFD;
              cnt <= 8'd0;
              rd_o <= len != 11'd0;
              addr_o <= 11'd0;
            end
          end
          SFD: begin
            cnt <= 8'd1;
            tx_data_o <= 4'hD;
          end
          DATA: begin
            ph <= 1'b1;
            tx_data_o <= hi;
            crc <= crc_nib(crc, hi);
          end
          PAD: begin
            ph <= 1'b1;
            tx_data_o <= 4'd0;
            crc <= crc_nib(crc, 4'd0);
          end
          FCS: if (cnt == 8'd7) begin
            st <= IFG;
            cnt <= 8'd0;
            tx_en_o <= 1'b0;
            tx_data_o <= 4'd0;
            tx_done_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
            tx_data_o <= ~crc[3:0];
            crc <= crc >> 4;
          end
          IFG: if (cnt == IFG_LAST) begin
            st <= IDLE;
            ready_o <= 1'b1;
          end else cnt <= cnt + 8'd1;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_iob_eth_mii_tx.sv
// tb_iob_eth_mii_tx: randomized frames checked against a byte-level Ethernet frame model
module tb_iob_eth_mii_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2];
  logic send [2];
  logic [10:0] flen [2];
  logic ready [2], done [2], rd [2], en [2];
  logic [10:0] addr [2];
  logic [7:0] data [2];
  logic [3:0] txd [2];
  logic [7:0] mem [2048];
  logic [3:0] nib [$];
  logic [3:0] exp_q [$];
  int reads [$];
  int n_assert = 0, n_fail = 0;
  int done_cnt, rdy_bad;
  iob_eth_mii_tx #(.PAD_EN(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .send_i(send[0]), .frame_len_i(flen[0]), .ready_o(ready[0]),
    .tx_done_o(done[0]), .rd_o(rd[0]), .addr_o(addr[0]), .data_i(data[0]), .tx_en_o(en[0]), .tx_data_o(txd[0])
  );
  iob_eth_mii_tx #(.PAD_EN(1)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .send_i(send[1]), .frame_len_i(flen[1]), .ready_o(ready[1]),
    .tx_done_o(done[1]), .rd_o(rd[1]), .addr_o(addr[1]), .data_i(data[1]), .tx_en_o(en[1]), .tx_data_o(txd[1])
  );
  // synchronous buffer: data valid the cycle after a read, garbage otherwise
  always @(posedge clk)
    for (int k = 0; k < 2; k++) data[k] <= rd[k] ? mem[addr[k]] : 8'($urandom);
  task automatic chk(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  task automatic build_exp(input int n, input bit pad);
    int t;
    logic [31:0] c;
    logic [7:0] b;
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    t = (pad && n < 60) ? 60 : n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < t; i++) begin
      b = (i < n) ? mem[i] : 8'h00;
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int j = 0; j < 8; j++) exp_q.push_back(c[4*j +: 4]);
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
  endtask
  task automatic start(input int k, input int n, input bit hold);
    chk("ready_before_send", ready[k], 1);
    flen[k] = 11'(n);
    send[k] = 1'b1;
    @(negedge clk);
    if (!hold) send[k] = 1'b0;
    chk("first_nibble", {en[k], txd[k]}, 5'h15);
  endtask
  task automatic capture(input int k);
    int cyc;
    nib.delete();
    reads.delete();
    done_cnt = 0;
    rdy_bad = 0;
    cyc = 0;
    while (en[k] && cyc < 5000) begin
      nib.push_back(txd[k]);
      if (rd[k]) reads.push_back(int'(addr[k]));
      if (ready[k]) rdy_bad++;
      if (done[k]) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("done_pulse", done[k], 1);
    chk("done_early", done_cnt, 0);
    chk("ready_busy", rdy_bad, 0);
  endtask
  task automatic check_frame(input int n, input bit pad);
    int bad;
    build_exp(n, pad);
    chk("frame_nibbles", nib.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < nib.size() && i < exp_q.size(); i++)
      if (nib[i] !== exp_q[i] && bad < 0) bad = i;
    chk("stream_first_bad_idx", bad, -1);
    chk("rd_count", reads.size(), n);
    bad = -1;
    for (int i = 0; i < reads.size(); i++)
      if (reads[i] != i && bad < 0) bad = i;
    chk("rd_order_first_bad", bad, -1);
  endtask
  task automatic wait_idle(input int k);
    int cyc, bad;
    cyc = 0;
    bad = 0;
    @(negedge clk);
    chk("done_width", done[k], 0);
    while (!ready[k] && cyc < 200) begin
      if (en[k] || txd[k] != 4'd0) bad++;
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", ready[k], 1);
    chk("ifg_quiet", bad, 0);
  endtask
  task automatic run(input int k, input int n);
    start(k, n, 1'b0);
    capture(k);
    check_frame(n, k == 1);
    wait_idle(k);
  endtask
  initial begin
    logic [31:0] f, r;
    int g, k, n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      send[i] = 1'b1;
      flen[i] = 11'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", ready[i], 1);
      chk("rst_done", done[i], 0);
      chk("rst_rd", rd[i], 0);
      chk("rst_addr", addr[i], 0);
      chk("rst_en", en[i], 0);
      chk("rst_txd", txd[i], 0);
      rst[i] = 1'b0;
      send[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    start(0, 9, 1'b0);
    capture(0);
    check_frame(9, 1'b0);
    chk("basic_len", nib.size(), 42);
    f = 32'd0;
    if (nib.size() >= 8) for (int j = 0; j < 8; j++) f[4*j +: 4] = nib[nib.size() - 8 + j];
    chk("basic_fcs", f, 32'hCBF43926);
    wait_idle(0);
    fill(10);
    start(1, 10, 1'b0);
    capture(1);
    check_frame(10, 1'b1);
    chk("pad_len", nib.size(), 144);
    r = 32'hFFFFFFFF;
    for (int i = 16; i + 1 < nib.size(); i += 2) r = crc_byte(r, {nib[i+1], nib[i]});
    chk("pad_residue", r, 32'hDEBB20E3);
    wait_idle(1);
    fill(1514);
    run(0, 1514);
    chk("long_len", nib.size(), 16 + 2 * 1514 + 8);
    fill(20);
    start(1, 20, 1'b1);
    capture(1);
    check_frame(20, 1'b1);
    g = 0;
    while (!en[1] && g < 100) begin
      if (ready[1] && g < 23) rdy_bad++;
      g++;
      @(negedge clk);
    end
    send[1] = 1'b0;
    chk("b2b_gap", g, 24);
    capture(1);
    check_frame(20, 1'b1);
    wait_idle(1);
    fill(64);
    start(1, 64, 1'b0);
    repeat (56) @(negedge clk);
    chk("byte20_low", txd[1], mem[20][3:0]);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("midrst_en", en[1], 0);
    chk("midrst_ready", ready[1], 1);
    chk("midrst_addr", addr[1], 0);
    chk("midrst_done", done[1], 0);
    chk("midrst_txd", txd[1], 0);
    @(negedge clk);
    chk("midrst_done_after", done[1], 0);
    fill(64);
    run(1, 64);
    run(1, 0);
    chk("len0_pad_len", nib.size(), 144);
    run(0, 0);
    chk("len0_nopad_len", nib.size(), 24);
    for (int t = 0; t < 6; t++) begin
      k = int'($urandom_range(1, 0));
      n = int'($urandom_range(100, 1));
      fill(n);
      run(k, n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
